// File: rtl/hazard_detection_unit.sv
// Pipeline hazard control: load-use bubbles, DE-branch load stalls and data-memory freezes.
// Optional performance counters are compiled in when HAZARD_PERF_CNT_EN is defined.
module hazard_detection_unit #(
    parameter logic [4:0] ZERO_REG = 5'd0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       de_valid,
    input  logic [4:0] decoded_rs1,
    input  logic [4:0] decoded_rs2,
    input  logic [1:0] de_data_dependency_check,
    input  logic       de_is_branch,
    input  logic       branch_taken,
    input  logic [4:0] ex_rd,
    input  logic [2:0] ex_wb_src,
    input  logic [4:0] ex_mem_op,
    input  logic [4:0] m1_rd,
    input  logic [2:0] m1_wb_src,
    input  logic [4:0] m1_mem_op,
    input  logic       dmem_req,
    input  logic       dmem_ready,
    output logic       stalled,
    output logic       pc_hold,
    output logic       if_de_hold,
    output logic       de_ex_bubble,
    output logic       de_ex_hold,
    output logic       ex_m1_hold,
    output logic       m1_m2_hold,
    output logic       m2_wb_bubble,
    output logic       if_de_flush,
    output logic [1:0] hazard_state
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [31:0] perf_hazard_stall_cnt,
    output logic [31:0] perf_mem_wait_cnt,
    output logic [31:0] perf_flush_cnt
`endif
);

    localparam logic [1:0] MEM_READ   = 2'b01;
    localparam logic [1:0] StRun      = 2'd0;
    localparam logic [1:0] StHazStall = 2'd1;
    localparam logic [1:0] StMemWait  = 2'd2;

    logic [1:0] state_q, state_d;
    logic [1:0] cnt_q, cnt_d;
    logic [1:0] ret_q, ret_d;

    logic ex_is_load, m1_is_load, ex_match, m1_match, mem_wait;
    logic [1:0] n_bubbles;
    logic hz_stall, freeze, legal_state;

    logic unused_mem_op_bits;
    assign unused_mem_op_bits = ^{ex_mem_op[2:0], m1_mem_op[2:0], ex_wb_src[1:0], m1_wb_src[1:0]};

    assign ex_is_load = ex_wb_src[2] & (ex_mem_op[4:3] == MEM_READ);
    assign m1_is_load = m1_wb_src[2] & (m1_mem_op[4:3] == MEM_READ);

    assign ex_match = (ex_rd != ZERO_REG) &
                      ((de_data_dependency_check[0] & (decoded_rs1 == ex_rd)) |
                       (de_data_dependency_check[1] & (decoded_rs2 == ex_rd)));
    assign m1_match = (m1_rd != ZERO_REG) &
                      ((de_data_dependency_check[0] & (decoded_rs1 == m1_rd)) |
                       (de_data_dependency_check[1] & (decoded_rs2 == m1_rd)));

    assign mem_wait    = dmem_req & ~dmem_ready;
    assign legal_state = (state_q != 2'd3);

    always_comb begin
        n_bubbles = 2'd0;
        if (de_valid) begin
            if (ex_is_load && ex_match) begin
                n_bubbles = de_is_branch ? 2'd2 : 2'd1;
            end else if (m1_is_load && m1_match && de_is_branch) begin
                n_bubbles = 2'd1;
            end
        end
    end

    always_comb begin
        hz_stall = 1'b0;
        freeze   = 1'b0;
        state_d  = state_q;
        cnt_d    = cnt_q;
        ret_d    = ret_q;
        case (state_q)
            StRun: begin
                if (mem_wait) begin
                    freeze  = 1'b1;
                    state_d = StMemWait;
                    ret_d   = StRun;
                end else if (n_bubbles != 2'd0) begin
                    hz_stall = 1'b1;
                    if (n_bubbles == 2'd2) begin
                        state_d = StHazStall;
                        cnt_d   = 2'd1;
                    end
                end
            end
            StHazStall: begin
                if (mem_wait) begin
                    freeze  = 1'b1;
                    state_d = StMemWait;
                    ret_d   = StHazStall;
                end else begin
                    hz_stall = 1'b1;
                    // The cycle that takes cnt to zero is the last stall cycle.
                    if (cnt_q <= 2'd1) begin
                        state_d = StRun;
                        cnt_d   = 2'd0;
                    end else begin
                        cnt_d = cnt_q - 2'd1;
                    end
                end
            end
            StMemWait: begin
                freeze = 1'b1;
                if (!mem_wait) begin
                    state_d = ret_q;
                end
            end
            default: begin
                state_d = StRun;
                cnt_d   = 2'd0;
                ret_d   = StRun;
            end
        endcase
        if (rst) begin
            hz_stall = 1'b0;
            freeze   = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StRun;
            cnt_q   <= 2'd0;
            ret_q   <= StRun;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ret_q   <= ret_d;
        end
    end

    assign stalled      = hz_stall | freeze;
    assign pc_hold      = hz_stall | freeze;
    assign if_de_hold   = hz_stall | freeze;
    assign de_ex_bubble = hz_stall & ~freeze;
    assign de_ex_hold   = freeze;
    assign ex_m1_hold   = freeze;
    assign m1_m2_hold   = freeze;
    assign m2_wb_bubble = freeze;
    assign if_de_flush  = branch_taken & de_is_branch & de_valid & ~stalled & ~rst & legal_state;
    assign hazard_state = rst ? StRun : state_q;

`ifdef HAZARD_PERF_CNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_hazard_stall_cnt <= 32'd0;
            perf_mem_wait_cnt     <= 32'd0;
            perf_flush_cnt        <= 32'd0;
        end else begin
            if (hz_stall && perf_hazard_stall_cnt != 32'hFFFF_FFFF) begin
                perf_hazard_stall_cnt <= perf_hazard_stall_cnt + 32'd1;
            end
            if (freeze && perf_mem_wait_cnt != 32'hFFFF_FFFF) begin
                perf_mem_wait_cnt <= perf_mem_wait_cnt + 32'd1;
            end
            if (if_de_flush && perf_flush_cnt != 32'hFFFF_FFFF) begin
                perf_flush_cnt <= perf_flush_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_hazard_detection_unit.sv
// Scoreboard bench for hazard_detection_unit: directed vectors push expected
// control words, a negedge monitor pops and compares them.
module tb_hazard_detection_unit;

    localparam logic [4:0] LOAD_OP = 5'b01000;  // mem_op[4:3] = MEM_READ (2'b01)
    localparam logic [2:0] LOAD_WB = 3'b100;

    // {stalled, pc_hold, if_de_hold, de_ex_bubble, de_ex_hold, ex_m1_hold,
    //  m1_m2_hold, m2_wb_bubble, if_de_flush}
    localparam logic [8:0] NONE = 9'b0000_0000_0;
    localparam logic [8:0] HZ   = 9'b1111_0000_0;
    localparam logic [8:0] FR   = 9'b1110_1111_0;
    localparam logic [8:0] FL   = 9'b0000_0000_1;

    logic       clk = 1'b0;
    logic       rst;
    logic       de_valid;
    logic [4:0] decoded_rs1, decoded_rs2;
    logic [1:0] dep;
    logic       de_is_branch, branch_taken;
    logic [4:0] ex_rd, ex_mem_op, m1_rd, m1_mem_op;
    logic [2:0] ex_wb_src, m1_wb_src;
    logic       dmem_req, dmem_ready;
    logic       stalled, pc_hold, if_de_hold, de_ex_bubble, de_ex_hold;
    logic       ex_m1_hold, m1_m2_hold, m2_wb_bubble, if_de_flush;
    logic [1:0] hazard_state;

    typedef struct {
        logic [10:0] v;
        string       tag;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    hazard_detection_unit #(.ZERO_REG(5'd0)) dut (
        .clk                      (clk),
        .rst                      (rst),
        .de_valid                 (de_valid),
        .decoded_rs1              (decoded_rs1),
        .decoded_rs2              (decoded_rs2),
        .de_data_dependency_check (dep),
        .de_is_branch             (de_is_branch),
        .branch_taken             (branch_taken),
        .ex_rd                    (ex_rd),
        .ex_wb_src                (ex_wb_src),
        .ex_mem_op                (ex_mem_op),
        .m1_rd                    (m1_rd),
        .m1_wb_src                (m1_wb_src),
        .m1_mem_op                (m1_mem_op),
        .dmem_req                 (dmem_req),
        .dmem_ready               (dmem_ready),
        .stalled                  (stalled),
        .pc_hold                  (pc_hold),
        .if_de_hold               (if_de_hold),
        .de_ex_bubble             (de_ex_bubble),
        .de_ex_hold               (de_ex_hold),
        .ex_m1_hold               (ex_m1_hold),
        .m1_m2_hold               (m1_m2_hold),
        .m2_wb_bubble             (m2_wb_bubble),
        .if_de_flush              (if_de_flush),
        .hazard_state             (hazard_state)
    );

    // Monitor: one expected word per cycle, compared mid-cycle.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            logic [10:0] got;
            e   = exp_q.pop_front();
            got = {stalled, pc_hold, if_de_hold, de_ex_bubble, de_ex_hold, ex_m1_hold,
                   m1_m2_hold, m2_wb_bubble, if_de_flush, hazard_state};
            checks++;
            if (got !== e.v) begin
                errors++;
                $display("FAIL %s: got=%b expected=%b", e.tag, got, e.v);
            end
        end
    end

    task automatic clear_in();
        de_valid     = 1'b1;
        decoded_rs1  = 5'd0;
        decoded_rs2  = 5'd0;
        dep          = 2'b00;
        de_is_branch = 1'b0;
        branch_taken = 1'b0;
        ex_rd        = 5'd0;
        ex_wb_src    = 3'd0;
        ex_mem_op    = 5'd0;
        m1_rd        = 5'd0;
        m1_wb_src    = 3'd0;
        m1_mem_op    = 5'd0;
        dmem_req     = 1'b0;
        dmem_ready   = 1'b0;
    endtask

    task automatic ex_load(input logic [4:0] rd);
        ex_rd = rd; ex_wb_src = LOAD_WB; ex_mem_op = LOAD_OP;
    endtask

    task automatic m1_load(input logic [4:0] rd);
        m1_rd = rd; m1_wb_src = LOAD_WB; m1_mem_op = LOAD_OP;
    endtask

    // Push expectation for the current cycle, then advance to just after the next edge.
    task automatic expect_cyc(input logic [8:0] ctrl, input logic [1:0] st, input string tag);
        exp_t e;
        e.v   = {ctrl, st};
        e.tag = tag;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    initial begin
        clear_in();
        rst = 1'b1;
        @(posedge clk);
        #1;
        // Reset overrides a live ALU hazard.
        ex_load(5'd5); decoded_rs1 = 5'd5; dep = 2'b01;
        expect_cyc(NONE, 2'd0, "reset_override");
        rst = 1'b0;
        clear_in();
        expect_cyc(NONE, 2'd0, "idle_after_reset");

        // ALU load-use: one stall, then load in M1 is harmless for a non-branch.
        ex_load(5'd5); decoded_rs1 = 5'd5; dep = 2'b01;
        expect_cyc(HZ, 2'd0, "alu_stall");
        clear_in(); decoded_rs1 = 5'd5; dep = 2'b01; m1_load(5'd5);
        expect_cyc(NONE, 2'd0, "alu_after");

        // Branch vs EX load: two stalls, no early flush.
        clear_in(); de_is_branch = 1'b1; branch_taken = 1'b1;
        decoded_rs2 = 5'd7; dep = 2'b10; ex_load(5'd7);
        expect_cyc(HZ, 2'd0, "br_ex_1");
        clear_in(); de_is_branch = 1'b1; branch_taken = 1'b1;
        decoded_rs2 = 5'd7; dep = 2'b10; m1_load(5'd7);
        expect_cyc(HZ, 2'd1, "br_ex_2");
        clear_in(); de_is_branch = 1'b1; branch_taken = 1'b1;
        decoded_rs2 = 5'd7; dep = 2'b10;
        expect_cyc(FL, 2'd0, "br_ex_flush");

        // Zero register and dependency bits.
        clear_in(); ex_load(5'd0); decoded_rs1 = 5'd0; dep = 2'b01;
        expect_cyc(NONE, 2'd0, "zero_reg");
        clear_in(); ex_load(5'd5); decoded_rs1 = 5'd5; dep = 2'b00;
        expect_cyc(NONE, 2'd0, "dep_none");
        clear_in(); ex_load(5'd6); decoded_rs2 = 5'd6; dep = 2'b01;
        expect_cyc(NONE, 2'd0, "dep_wrong_bit");
        clear_in(); de_valid = 1'b0; ex_load(5'd5); decoded_rs1 = 5'd5; dep = 2'b01;
        expect_cyc(NONE, 2'd0, "de_invalid");

        // Branch vs M1 load: one stall, then flush.
        clear_in(); de_is_branch = 1'b1; branch_taken = 1'b1;
        decoded_rs1 = 5'd9; dep = 2'b01; m1_load(5'd9);
        expect_cyc(HZ, 2'd0, "br_m1_stall");
        clear_in(); de_is_branch = 1'b1; branch_taken = 1'b1;
        decoded_rs1 = 5'd9; dep = 2'b01;
        expect_cyc(FL, 2'd0, "br_m1_flush");
        clear_in(); decoded_rs1 = 5'd9; dep = 2'b01; m1_load(5'd9);
        expect_cyc(NONE, 2'd0, "m1_load_alu");

        // Memory wait inside HAZ_STALL: 4 freezes, then the remaining hazard cycle.
        clear_in(); de_is_branch = 1'b1; decoded_rs1 = 5'd3; dep = 2'b01; ex_load(5'd3);
        expect_cyc(HZ, 2'd0, "mw_enter_haz");
        clear_in(); de_is_branch = 1'b1; decoded_rs1 = 5'd3; dep = 2'b01; m1_load(5'd3);
        dmem_req = 1'b1;
        expect_cyc(FR, 2'd1, "mw_freeze_1");
        expect_cyc(FR, 2'd2, "mw_freeze_2");
        expect_cyc(FR, 2'd2, "mw_freeze_3");
        dmem_ready = 1'b1;
        expect_cyc(FR, 2'd2, "mw_freeze_done");
        dmem_req = 1'b0; dmem_ready = 1'b0;
        expect_cyc(HZ, 2'd1, "mw_haz_resume");
        clear_in();
        expect_cyc(NONE, 2'd0, "mw_back_run");

        // Load-use and mem_wait together in RUN: freeze wins, hazard re-evaluated after.
        clear_in(); ex_load(5'd4); decoded_rs1 = 5'd4; dep = 2'b01; dmem_req = 1'b1;
        expect_cyc(FR, 2'd0, "both_freeze");
        dmem_ready = 1'b1;
        expect_cyc(FR, 2'd2, "both_done");
        dmem_req = 1'b0; dmem_ready = 1'b0;
        expect_cyc(HZ, 2'd0, "both_haz_after");
        clear_in();
        expect_cyc(NONE, 2'd0, "both_idle");

        // Taken branch, no hazard; no flush when DE is invalid.
        clear_in(); de_is_branch = 1'b1; branch_taken = 1'b1;
        expect_cyc(FL, 2'd0, "taken_flush");
        de_valid = 1'b0;
        expect_cyc(NONE, 2'd0, "taken_invalid");

        // Reset asserted mid HAZ_STALL, between clock edges.
        clear_in(); de_is_branch = 1'b1; decoded_rs1 = 5'd8; dep = 2'b01; ex_load(5'd8);
        expect_cyc(HZ, 2'd0, "rst_enter_haz");
        rst = 1'b1;
        expect_cyc(NONE, 2'd0, "rst_mid_stall");
        clear_in();
        rst = 1'b0;
        expect_cyc(NONE, 2'd0, "rst_release");
        expect_cyc(NONE, 2'd0, "rst_no_residual");

        for (int i = 0; i < 4 && exp_q.size() > 0; i++) begin
            @(posedge clk);
        end
        if (exp_q.size() > 0) begin
            errors++;
            $display("FAIL drain: got=%0d pending expected=0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
